piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out stage that sits directly upstream of shift_reg.
//   Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per cycle on
//   ser_d, with ser_ena/ser_dir wired straight to shift_reg's d/ena/dir pins.
//   After WIDTH enabled cycles the downstream shift_reg holds the original word.
// PARAMETERS
//   WIDTH  8  word width in bits; must match downstream shift_reg MSB; WIDTH >= 2
// PORTS
//   clk        in   1      single clock; all logic on posedge
//   reset_n    in   1      synchronous, active-low reset
//   in_valid   in   1      in_data/in_dir valid this cycle
//   in_ready   out  1      block can accept a word this cycle
//   in_data    in   WIDTH  parallel word
//   in_dir     in   1      0 = MSB first (shift_reg dir 0), 1 = LSB first (shift_reg dir 1)
//   out_hold   in   1      downstream stall; freezes serialization
//   abort      in   1      synchronous flush of the word in flight
//   ser_d      out  1      serial data bit -> shift_reg.d
//   ser_ena    out  1      bit valid / shift enable -> shift_reg.ena
//   ser_dir    out  1      latched in_dir of word in flight -> shift_reg.dir
//   word_done  out  1      one-cycle pulse coincident with last bit of a word
// BEHAVIOUR
//   - Reset: state IDLE, data reg 0, bit counter 0, dir reg 0; ser_d=0, ser_ena=0, ser_dir=0,
//     word_done=0; in_ready=0 while reset_n=0 (in_ready is gated by reset_n).
//   - FSM: IDLE, SHIFT. IDLE->SHIFT on accept; SHIFT->IDLE after last bit unless a new word is
//     accepted that cycle (stays in SHIFT, counter reloads to 0).
//   - Accept = in_valid & in_ready. in_ready = reset_n & ~abort & (IDLE | (SHIFT & last & ~out_hold)).
//     A zero-bubble back-to-back transfer is supported.
//   - Latency: word accepted at edge N; bit 0 appears on ser_d with ser_ena=1 in cycle N+1.
//     Bits occupy WIDTH consecutive un-held cycles.
//   - Bit order: dir 0 sends data[WIDTH-1] down to data[0]; dir 1 sends data[0] up to data[WIDTH-1].
//     Implemented as a shift of the internal data reg in the direction given by the latched dir.
//   - ser_ena = (state==SHIFT) & ~out_hold (combinational). ser_d and ser_dir come from registers.
//   - out_hold=1: counter and data reg frozen, ser_d holds its value, ser_ena=0, no word_done.
//   - last = (counter == WIDTH-1). word_done = ser_ena & last.
//   - abort=1 at an edge: next state IDLE, counter 0, data reg 0; no word_done for the flushed word.
//     abort has priority over accept; abort in IDLE has no effect beyond blocking the accept.
//   - Reset mid-word: same as abort plus all registers at reset values. No partial word_done.
//   - Counter width $clog2(WIDTH); it never exceeds WIDTH-1, so no wrap is needed.
// STRUCTURE
//   - Shared constants go in core_defs.vh: DIR_MSB_FIRST=0, DIR_LSB_FIRST=1, ST_IDLE=0, ST_SHIFT=1.
//     The same DIR_* values are used by shift_reg instantiations.
//   - One sub-module: bit_counter #(WIDTH), with clear, enable and terminal-count (last) outputs.
//   - FSM, data reg and handshake logic live in piso_serializer. Top-level integration chains
//     piso_serializer -> shift_reg.
// TESTING (WIDTH=8, shift_reg MSB=8 attached downstream)
//   1 MSB first: load 8'hA5, dir 0 -> ser_d 1,0,1,0,0,1,0,1 over cycles N+1..N+8; ser_ena high
//     8 cycles; word_done in cycle N+8; shift_reg.out = 8'hA5.
//   2 LSB first: load 8'h3C, dir 1 -> ser_d 0,0,1,1,1,1,0,0; shift_reg.out = 8'h3C; ser_dir=1
//     throughout.
//   3 Back-to-back: 8'hA5 then 8'h5A, in_valid held high -> 16 consecutive ser_ena cycles;
//     word_done in cycles 8 and 16; in_ready high only in cycle 8 and the IDLE cycles.
//   4 Hold: 8'hA5, out_hold=1 for 3 cycles after bit 3 -> ser_ena=0 for those 3 cycles;
//     bit sequence intact; word_done in cycle N+11; shift_reg.out = 8'hA5.
//   5 Abort: abort after bit 4 of 8'hA5 -> ser_ena=0 from next cycle, no word_done; next word
//     8'hFF sends 8 ones with word_done.
//   6 Reset mid-word: reset_n=0 for 2 cycles during bit 5 -> all outputs 0, in_ready=0 during
//     reset, in_ready=1 the first cycle after release; a new word 8'h81 serializes correctly.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_serializer_pkg
//   Shared constants and types for the parallel-in/serial-out serializer and
//   the shift_reg it feeds.
//   - DIR_MSB_FIRST / DIR_LSB_FIRST: serialization direction. The same values
//     drive shift_reg.dir, so a word shifted out in one direction lands in the
//     downstream register in its original bit positions.
//   - state_e: serializer FSM states (IDLE waits for a word, SHIFT emits bits).
//   - first_bit(): selects the bit that leaves first for a given direction.
// -----------------------------------------------------------------------------
package piso_serializer_pkg;

  // Serialization direction, shared with shift_reg.dir.
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // Serializer FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Pick the outgoing bit from the two candidate ends of a word.
  // msb_bit / lsb_bit are the two ends; dir selects which one leaves first.
  function automatic logic first_bit(input logic dir, input logic msb_bit,
                                     input logic lsb_bit);
    logic b;
    if (dir == DIR_MSB_FIRST) begin
      b = msb_bit;
    end else begin
      b = lsb_bit;
    end
    return b;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_serializer_bit_counter
//   Counts the bit positions of the word currently being serialized.
//   Ports:
//     clk       in   clock, posedge
//     reset_n   in   synchronous active-low reset (count -> 0)
//     i_clear   in   synchronous clear to 0 (abort, word accept, word end)
//     i_enable  in   advance by one (an un-held, non-final bit was emitted)
//     o_last    out  terminal count: counter == WIDTH-1
//   The owner never enables the counter on its terminal count (it clears it
//   instead), so the count stays within 0..WIDTH-1 and no wrap is needed.
// -----------------------------------------------------------------------------
module piso_serializer_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  // Bit position register: reset/clear win, otherwise step on enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= {CW{1'b0}};
    end else if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_enable && (r_count != LAST_COUNT)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_last = (r_count == LAST_COUNT);

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in/serial-out stage placed directly upstream of shift_reg.
//   A WIDTH-bit word is accepted over valid/ready and emitted one bit per
//   un-held cycle on ser_d; ser_ena/ser_dir drive shift_reg.ena/dir, so after
//   WIDTH enabled cycles shift_reg holds the original word.
//   Ports:
//     clk        in   clock, all logic on posedge
//     reset_n    in   synchronous active-low reset
//     in_valid   in   in_data/in_dir valid this cycle
//     in_ready   out  a word can be accepted this cycle (gated by reset_n)
//     in_data    in   parallel word [WIDTH-1:0]
//     in_dir     in   0 = MSB first, 1 = LSB first
//     out_hold   in   downstream stall, freezes serialization
//     abort      in   synchronous flush of the word in flight
//     ser_d      out  serial data bit          -> shift_reg.d
//     ser_ena    out  bit valid / shift enable -> shift_reg.ena
//     ser_dir    out  direction of word        -> shift_reg.dir
//     word_done  out  pulse coincident with the last bit of a word
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             out_hold,
  input  logic             abort,
  output logic             ser_d,
  output logic             ser_ena,
  output logic             ser_dir,
  output logic             word_done
);

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic             r_ser_d;

  logic             w_last;
  logic             w_shifting;
  logic             w_accept;
  logic             w_cnt_clear;
  logic             w_cnt_enable;
  logic [WIDTH-1:0] w_data_shift;
  logic             w_next_bit;
  logic             w_load_bit;

  // Handshake: a new word may enter while idle, or on the final un-held bit
  // of the current word so back-to-back words run without a bubble.
  assign in_ready = reset_n & ~abort &
                    ((r_state == ST_IDLE) |
                     ((r_state == ST_SHIFT) & w_last & ~out_hold));
  assign w_accept = in_valid & in_ready;

  // A bit is presented to shift_reg whenever a word is in flight and the
  // downstream is not stalling.
  assign w_shifting = (r_state == ST_SHIFT) & ~out_hold;
  assign ser_ena    = w_shifting;
  assign word_done  = w_shifting & w_last;
  assign ser_d      = r_ser_d;
  assign ser_dir    = r_dir;

  // The data register moves toward the outgoing end, so the next bit to send
  // is always at the same end of the shifted word.
  assign w_data_shift = (r_dir == DIR_MSB_FIRST) ? {r_data[WIDTH-2:0], 1'b0}
                                                 : {1'b0, r_data[WIDTH-1:1]};
  assign w_next_bit   = first_bit(r_dir, w_data_shift[WIDTH-1], w_data_shift[0]);
  assign w_load_bit   = first_bit(in_dir, in_data[WIDTH-1], in_data[0]);

  // Counter restarts on flush, on a new word, and after the final bit.
  assign w_cnt_clear  = abort | w_accept | (w_shifting & w_last);
  assign w_cnt_enable = w_shifting & ~w_last;

  piso_serializer_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_enable),
    .o_last   (w_last)
  );

  // FSM, data register and serial output register. Priority: reset, abort,
  // accept, then normal shifting; out_hold freezes everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_data  <= {WIDTH{1'b0}};
      r_dir   <= DIR_MSB_FIRST;
      r_ser_d <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_data  <= {WIDTH{1'b0}};
      r_dir   <= r_dir;
      r_ser_d <= 1'b0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_data  <= in_data;
      r_dir   <= in_dir;
      r_ser_d <= w_load_bit;
    end else if (w_shifting) begin
      if (w_last) begin
        // Final bit leaves this cycle and nothing new arrived.
        r_state <= ST_IDLE;
        r_data  <= {WIDTH{1'b0}};
        r_dir   <= r_dir;
        r_ser_d <= 1'b0;
      end else begin
        r_state <= ST_SHIFT;
        r_data  <= w_data_shift;
        r_dir   <= r_dir;
        r_ser_d <= w_next_bit;
      end
    end else begin
      r_state <= r_state;
      r_data  <= r_data;
      r_dir   <= r_dir;
      r_ser_d <= r_ser_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Bench for piso_serializer (WIDTH=8) with a behavioural shift_reg attached
//   to ser_d/ser_ena/ser_dir. A word-level model (word, direction, bit index)
//   predicts every output each cycle; directed scenarios pin the model with
//   literal expectations, then a randomized phase exercises holds, aborts,
//   resets and back-to-back traffic.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         out_hold;
  logic         abort;
  logic         ser_d;
  logic         ser_ena;
  logic         ser_dir;
  logic         word_done;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .out_hold  (out_hold),
    .abort     (abort),
    .ser_d     (ser_d),
    .ser_ena   (ser_ena),
    .ser_dir   (ser_dir),
    .word_done (word_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Word-level model state.
  bit         m_known    = 1'b0;
  bit         m_active   = 1'b0;
  bit         m_pristine = 1'b0;
  logic [W-1:0] m_word   = '0;
  bit         m_dir      = 1'b0;
  int         m_idx      = 0;

  // Downstream shift_reg model and its pending end-of-word check.
  logic [W-1:0] sr      = '0;
  bit           sr_pend = 1'b0;
  logic [W-1:0] sr_want = '0;
  logic         s_ena, s_d, s_dir;

  // Observation counters for the directed scenarios.
  logic [W-1:0] seq = '0;
  int ena_cnt = 0, done_cnt = 0, first_done_cyc = 0, last_done_cyc = 0;
  int run_cur = 0, run_max = 0, rdy_busy_cnt = 0, dir1_cnt = 0;

  bit e_ena, e_last, e_rdy, e_bit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_ready();
    return reset_n && !abort &&
           (!m_active || ((m_idx == W-1) && !out_hold));
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      if (sr_pend) begin
        chk("shift_reg_word", sr, sr_want);
        sr_pend = 1'b0;
      end
      e_ena  = m_active && !out_hold;
      e_last = m_active && (m_idx == W-1);
      e_rdy  = model_ready();
      e_bit  = m_dir ? m_word[m_idx] : m_word[W-1-m_idx];
      chk("ser_ena", ser_ena, e_ena);
      chk("word_done", word_done, e_ena && e_last);
      chk("in_ready", in_ready, e_rdy);
      if (e_ena) begin
        chk("ser_d", ser_d, e_bit);
        chk("ser_dir", ser_dir, m_dir);
      end
      if (m_pristine) begin
        chk("idle_ser_d", ser_d, 1'b0);
        chk("idle_ser_dir", ser_dir, 1'b0);
      end
      if (e_ena && e_last) begin
        sr_pend = 1'b1;
        sr_want = m_word;
      end
      if (ser_ena === 1'b1) begin
        seq = {seq[W-2:0], ser_d};
        ena_cnt++;
        run_cur++;
        if (run_cur > run_max) run_max = run_cur;
        if (in_ready === 1'b1) rdy_busy_cnt++;
        if (ser_dir === 1'b1) dir1_cnt++;
      end else begin
        run_cur = 0;
      end
      if (word_done === 1'b1) begin
        if (done_cnt == 0) first_done_cyc = cyc;
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
    s_ena = ser_ena;
    s_d   = ser_d;
    s_dir = ser_dir;
  end

  // Model update at the active edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    cyc++;
    if (m_known && (s_ena === 1'b1)) begin
      sr = (s_dir === 1'b1) ? {s_d, sr[W-1:1]} : {sr[W-2:0], s_d};
    end
    if (!reset_n) begin
      m_known    = 1'b1;
      m_active   = 1'b0;
      m_idx      = 0;
      m_pristine = 1'b1;
    end else if (m_known) begin
      if (abort) begin
        m_active = 1'b0;
        m_idx    = 0;
      end else if (in_valid && model_ready()) begin
        m_active   = 1'b1;
        m_word     = in_data;
        m_dir      = in_dir;
        m_idx      = 0;
        m_pristine = 1'b0;
      end else if (m_active && !out_hold) begin
        if (m_idx == W-1) m_active = 1'b0;
        else m_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    seq = '0; ena_cnt = 0; done_cnt = 0; first_done_cyc = 0; last_done_cyc = 0;
    run_cur = 0; run_max = 0; rdy_busy_cnt = 0; dir1_cnt = 0;
  endtask

  task automatic send(input logic [W-1:0] word, input logic dir);
    in_valid = 1'b1;
    in_data  = word;
    in_dir   = dir;
    tick();
    in_valid = 1'b0;
  endtask

  int c0;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
    out_hold = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst_ser_ena", ser_ena, 1'b0);
    chk("rst_ser_d", ser_d, 1'b0);
    chk("rst_ser_dir", ser_dir, 1'b0);
    chk("rst_word_done", word_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1'b1);
    tick();

    // 1: MSB first.
    clear_obs(); c0 = cyc;
    send(8'hA5, 1'b0);
    repeat (9) tick();
    chk("t1_seq", seq, 8'hA5);
    chk("t1_ena_cnt", ena_cnt, 8);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cycle", last_done_cyc - c0, 8);
    chk("t1_shift_reg", sr, 8'hA5);

    // 2: LSB first.
    clear_obs();
    send(8'h3C, 1'b1);
    repeat (9) tick();
    chk("t2_seq", seq, 8'h3C);
    chk("t2_dir_cnt", dir1_cnt, 8);
    chk("t2_shift_reg", sr, 8'h3C);

    // 3: back-to-back with in_valid held high.
    clear_obs(); c0 = cyc;
    in_valid = 1'b1; in_data = 8'hA5; in_dir = 1'b0;
    tick();
    in_data = 8'h5A;
    repeat (8) tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("t3_run", run_max, 16);
    chk("t3_done_cnt", done_cnt, 2);
    chk("t3_done1_cycle", first_done_cyc - c0, 8);
    chk("t3_done2_cycle", last_done_cyc - c0, 16);
    chk("t3_ready_busy", rdy_busy_cnt, 2);
    chk("t3_seq", seq, 8'h5A);
    chk("t3_shift_reg", sr, 8'h5A);

    // 4: three hold cycles after bit 3.
    clear_obs(); c0 = cyc;
    send(8'hA5, 1'b0);
    repeat (4) tick();
    out_hold = 1'b1;
    repeat (3) tick();
    out_hold = 1'b0;
    repeat (9) tick();
    chk("t4_seq", seq, 8'hA5);
    chk("t4_ena_cnt", ena_cnt, 8);
    chk("t4_done_cycle", last_done_cyc - c0, 11);
    chk("t4_shift_reg", sr, 8'hA5);

    // 5: abort after bit 4, then a clean word.
    clear_obs();
    send(8'hA5, 1'b0);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    chk("t5_abort_done", done_cnt, 0);
    chk("t5_abort_ena", ena_cnt, 6);
    clear_obs();
    send(8'hFF, 1'b0);
    repeat (9) tick();
    chk("t5_seq", seq, 8'hFF);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_shift_reg", sr, 8'hFF);

    // 6: reset during bit 5.
    clear_obs();
    send(8'hA5, 1'b1);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    chk("t6_rst_ena", ser_ena, 1'b0);
    chk("t6_rst_d", ser_d, 1'b0);
    chk("t6_rst_dir", ser_dir, 1'b0);
    chk("t6_rst_ready", in_ready, 1'b0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("t6_release_ready", in_ready, 1'b1);
    chk("t6_no_done", done_cnt, 0);
    clear_obs();
    send(8'h81, 1'b0);
    repeat (9) tick();
    chk("t6_seq", seq, 8'h81);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_shift_reg", sr, 8'h81);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset_n  = ($urandom_range(0, 199) != 0);
      abort    = ($urandom_range(0, 39) == 0);
      out_hold = ($urandom_range(0, 4) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
      in_dir   = 1'($urandom_range(0, 1));
      tick();
    end
    reset_n = 1'b1; abort = 1'b0; out_hold = 1'b0; in_valid = 1'b0;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
